wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter LD_DEPTH, default 2, giving the maximum number of outstanding loads (power of two, at least 2).
REQ-002 The block SHALL have the port clk, in, 1, clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, in, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have the ports alu_we_i (in, 1), alu_waddr_i (in, 5) and alu_wdata_i (in, 32): single-cycle ALU result from ex.
REQ-005 The block SHALL have the ports ld_issue_i (in, 1), ld_rd_i (in, 5), ld_funct3_i (in, 3) and ld_addr_lo_i (in, 2): load issue from ex, carrying destination, width/sign code and byte offset.
REQ-006 The block SHALL have the port ld_issue_ready_o, out, 1: a load may be issued this cycle.
REQ-007 The block SHALL have the ports ld_rsp_valid_i (in, 1), ld_rsp_data_i (in, 32) and ld_rsp_ready_o (out, 1): raw word returned by data memory.
REQ-008 The block SHALL have the ports we_o (out, 1), waddr_o (out, 5) and wdata_o (out, 32): write port driven into the register file.
REQ-009 The block SHALL have the port busy_o, out, 32: bit n set means xn has a pending load; id stalls on any source or destination with its bit set.

Function
REQ-010 An issue SHALL be accepted when ld_issue_i && ld_issue_ready_o; on acceptance, {rd, funct3, addr_lo} are pushed into an in-order tag FIFO of depth LD_DEPTH.
REQ-011 ld_issue_ready_o SHALL be (count < LD_DEPTH) && !busy_o[ld_rd_i]; it stays low even when the same rd completes in that cycle (conservative).
REQ-012 Accepting an issue with rd != 0 SHALL set busy_o[rd] at the next edge; an issue to x0 SHALL occupy a FIFO slot but never set a busy bit.
REQ-013 ld_rsp_ready_o SHALL be (count != 0) && !(alu_we_i && alu_waddr_i != 0); a response is consumed when ld_rsp_valid_i && ld_rsp_ready_o.
REQ-014 ALU writes SHALL take priority over load responses; a blocked response holds and is consumed in a later cycle.
REQ-015 Responses SHALL be matched to the FIFO head (in order); a consumed response pops the head and clears busy_o[head.rd] at the next edge.
REQ-016 Extraction SHALL work as follows: byte = data[8*addr_lo +: 8]; half = addr_lo[1] ? data[31:16] : data[15:0].
REQ-017 Extension SHALL follow funct3: 000 sign-extends the byte, 001 sign-extends the half, 100 zero-extends the byte, 101 zero-extends the half, and 010 and every other code pass the full word.
REQ-018 Write-back outputs SHALL be registered with one-cycle latency: an ALU write or consumed response in cycle N appears on we_o/waddr_o/wdata_o in cycle N+1.
REQ-019 we_o SHALL be 0 whenever the selected destination is x0; waddr_o and wdata_o are don't-care when we_o is 0.
REQ-020 A simultaneous issue and consume in the same cycle SHALL apply both: count is unchanged, and the set and clear of busy bits for different rds are both applied.
REQ-021 The FIFO pointers SHALL wrap modulo LD_DEPTH.
REQ-022 The block SHALL NOT enforce ordering between ALU writes and pending loads to the same rd; id guarantees it via busy_o.

Reset
REQ-023 While rst is high at an edge, we_o, waddr_o, wdata_o and busy_o SHALL be 0 and the FIFO emptied (count 0); reset mid-operation discards all outstanding loads.
REQ-024 After reset, ld_rsp_ready_o SHALL be 0 (FIFO empty), so stale memory responses are not consumed; ld_issue_ready_o SHALL be 1.

Structure
REQ-025 defines.v SHALL hold REG_BUS, REG_ADDR_BUS, ZERO_REG, the load funct3 codes (LB/LH/LW/LBU/LHU) and the default WB_LD_DEPTH.
REQ-026 The tag FIFO SHALL be a sub-module ld_tag_fifo (10-bit entries, LD_DEPTH deep, push/pop/count), instantiated once; extension and arbitration live in wb_stage.

Verification
REQ-027 Scenario: ALU write x5=0x1234 in cycle N -> we_o=1, waddr_o=5, wdata_o=0x00001234 in N+1; ALU write to x0 -> we_o=0.
REQ-028 Scenario: issue LB to x7 with addr_lo=3, response 0x80FF_FF00 -> wdata_o=0xFFFFFF80 and busy_o[7] 1 -> 0; same data with LBU -> 0x00000080; LHU with addr_lo=2 -> 0x000080FF.
REQ-029 Scenario: two loads to x3 then x4 (FIFO full, ld_issue_ready_o=0), responses 0xA then 0xB -> x3=0xA, then x4=0xB, in order.
REQ-030 Scenario: ALU write to x9 and load response valid in the same cycle -> ld_rsp_ready_o=0, x9 written first, load written one cycle after the ALU write.
REQ-031 Scenario: issue to x6 while busy_o[6]=1 -> ld_issue_ready_o=0; issue to x0 -> consumed response gives we_o=0 and busy_o unchanged.
REQ-032 Scenario: rst asserted with 2 loads pending -> busy_o=0, ld_rsp_ready_o=0, and a late response is ignored.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: bus widths, load
// width codes, the load tag layout and the load data extraction helper.
package wb_stage_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int WB_LD_DEPTH  = 2;

    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG = '0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] rd;
        logic [2:0]              funct3;
        logic [1:0]              addr_lo;
    } ld_tag_t;

    // Byte lane picked by the low address bits, half by addr_lo[1].
    function automatic logic [REG_BUS-1:0] load_extend(input logic [2:0] funct3,
                                                       input logic [1:0] addr_lo,
                                                       input logic [REG_BUS-1:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [REG_BUS-1:0] r;
        b = data[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            LB:      r = {{24{b[7]}}, b};
            LH:      r = {{16{h[15]}}, h};
            LBU:     r = {24'b0, b};
            LHU:     r = {16'b0, h};
            LW:      r = data;
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Ex/memory-facing signals of the write-back stage; master drives requests,
// slave is the write-back stage itself.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                    alu_we_i;
    logic [REG_ADDR_BUS-1:0] alu_waddr_i;
    logic [REG_BUS-1:0]      alu_wdata_i;

    logic                    ld_issue_i;
    logic [REG_ADDR_BUS-1:0] ld_rd_i;
    logic [2:0]              ld_funct3_i;
    logic [1:0]              ld_addr_lo_i;
    logic                    ld_issue_ready_o;

    logic                    ld_rsp_valid_i;
    logic [REG_BUS-1:0]      ld_rsp_data_i;
    logic                    ld_rsp_ready_o;

    logic                    we_o;
    logic [REG_ADDR_BUS-1:0] waddr_o;
    logic [REG_BUS-1:0]      wdata_o;
    logic [REG_BUS-1:0]      busy_o;

    modport slave (
        input  alu_we_i, alu_waddr_i, alu_wdata_i,
        input  ld_issue_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i,
        output ld_issue_ready_o,
        input  ld_rsp_valid_i, ld_rsp_data_i,
        output ld_rsp_ready_o,
        output we_o, waddr_o, wdata_o, busy_o
    );

    modport master (
        output alu_we_i, alu_waddr_i, alu_wdata_i,
        output ld_issue_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i,
        input  ld_issue_ready_o,
        output ld_rsp_valid_i, ld_rsp_data_i,
        input  ld_rsp_ready_o,
        input  we_o, waddr_o, wdata_o, busy_o
    );

endinterface

// File: rtl/wb_stage_ld_tag_fifo.sv
// In-order tag FIFO for outstanding loads; DEPTH must be a power of two so
// the pointers wrap by natural overflow.
module ld_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates single-cycle ALU results against in-order load
// responses, extends load data and tracks per-register pending-load bits.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int LD_DEPTH = WB_LD_DEPTH
) (
    input logic      clk,
    input logic      rst,
    wb_stage_if.slave bus
);

    localparam int CW = $clog2(LD_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    ld_tag_t            new_tag;
    ld_tag_t            head;
    logic [CW-1:0]      count;
    logic               alu_win;
    logic               issue;
    logic               consume;
    logic [REG_BUS-1:0] busy_q;
    logic [REG_BUS-1:0] busy_nxt;
    logic               we_q;
    logic [REG_ADDR_BUS-1:0] waddr_q;
    logic [REG_BUS-1:0] wdata_q;

    assign new_tag = '{rd: bus.ld_rd_i, funct3: bus.ld_funct3_i, addr_lo: bus.ld_addr_lo_i};

    // An ALU write to x0 writes nothing, so it does not block a response.
    assign alu_win = bus.alu_we_i && (bus.alu_waddr_i != ZERO_REG);

    assign bus.ld_issue_ready_o = (count < DEPTH_C) && !busy_q[bus.ld_rd_i];
    assign bus.ld_rsp_ready_o   = (count != '0) && !alu_win;

    assign issue   = bus.ld_issue_i && bus.ld_issue_ready_o;
    assign consume = bus.ld_rsp_valid_i && bus.ld_rsp_ready_o;

    ld_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .W     ($bits(ld_tag_t))
    ) u_ld_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .din   (new_tag),
        .pop   (consume),
        .dout  (head),
        .count (count)
    );

    // Issue can never target a busy rd, so set and clear never collide.
    always_comb begin
        busy_nxt = busy_q;
        if (consume && head.rd != ZERO_REG) busy_nxt[head.rd] = 1'b0;
        if (issue && bus.ld_rd_i != ZERO_REG) busy_nxt[bus.ld_rd_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (alu_win) begin
                we_q    <= 1'b1;
                waddr_q <= bus.alu_waddr_i;
                wdata_q <= bus.alu_wdata_i;
            end else if (consume) begin
                we_q    <= (head.rd != ZERO_REG);
                waddr_q <= head.rd;
                wdata_q <= load_extend(head.funct3, head.addr_lo, bus.ld_rsp_data_i);
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign bus.we_o    = we_q;
    assign bus.waddr_o = waddr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle expected write-back pushed to a
// queue when stimulus is driven, popped and compared one cycle later.
module tb_wb_stage;
    import wb_stage_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    wb_exp_t exp_q[$];
    wb_exp_t e;

    wb_stage_if bus();

    wb_stage #(.LD_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_we_i       = 1'b0;
        bus.alu_waddr_i    = '0;
        bus.alu_wdata_i    = '0;
        bus.ld_issue_i     = 1'b0;
        bus.ld_rd_i        = '0;
        bus.ld_funct3_i    = LW;
        bus.ld_addr_lo_i   = '0;
        bus.ld_rsp_valid_i = 1'b0;
        bus.ld_rsp_data_i  = '0;
    endtask

    task automatic push_exp(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_exp_t x;
        x.we = we; x.a = a; x.d = d;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.ld_rsp_valid_i = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.we_o !== 1'b0 || bus.waddr_o !== 5'd0 || bus.wdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_wb: we=%0b waddr=%0d wdata=%h, want 0/0/0", bus.we_o, bus.waddr_o, bus.wdata_o);
        end
        n_cmp++;
        if (bus.busy_o !== 32'd0) begin
            n_bad++; $display("FAIL reset_busy: got %h, want 0", bus.busy_o);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.ld_rsp_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp_ready: got %0b, want 0", bus.ld_rsp_ready_o);
        end
        n_cmp++;
        if (bus.ld_issue_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_issue_ready: got %0b, want 1", bus.ld_issue_ready_o);
        end
        push_exp(1'b0, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we) begin
            n_bad++; $display("FAIL reset_stale_rsp: we=%0b, want %0b", bus.we_o, e.we);
        end
        idle_inputs();
        exp_q.delete();
    endtask

    task automatic test_alu();
        bus.alu_we_i = 1'b1; bus.alu_waddr_i = 5'd5; bus.alu_wdata_i = 32'h1234;
        push_exp(1'b1, 5'd5, 32'h0000_1234);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL alu_x5: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        bus.alu_waddr_i = 5'd0; bus.alu_wdata_i = 32'hDEAD_BEEF;
        push_exp(1'b0, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we) begin
            n_bad++; $display("FAIL alu_x0: we=%0b, want %0b", bus.we_o, e.we);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3 [4] = '{LB, LBU, LHU, LH};
        logic [1:0]  lo [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
        logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_FF00};
        for (int i = 0; i < 4; i++) begin
            bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd7;
            bus.ld_funct3_i = f3[i]; bus.ld_addr_lo_i = lo[i];
            tick();
            idle_inputs();
            n_cmp++;
            if (bus.busy_o[7] !== 1'b1) begin
                n_bad++; $display("FAIL ld_busy_set[%0d]: got %0b, want 1", i, bus.busy_o[7]);
            end
            bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = 32'h80FF_FF00;
            push_exp(1'b1, 5'd7, ex[i]);
            tick();
            idle_inputs();
            e = exp_q.pop_front(); n_cmp++;
            if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
                n_bad++;
                $display("FAIL ld_ext[%0d]: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                         i, bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
            end
            n_cmp++;
            if (bus.busy_o[7] !== 1'b0) begin
                n_bad++; $display("FAIL ld_busy_clr[%0d]: got %0b, want 0", i, bus.busy_o[7]);
            end
        end
    endtask

    task automatic test_in_order();
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd3; bus.ld_funct3_i = LW;
        tick();
        bus.ld_rd_i = 5'd4;
        tick();
        bus.ld_rd_i = 5'd5;
        #1;
        n_cmp++;
        if (bus.ld_issue_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL fifo_full_ready: got %0b, want 0", bus.ld_issue_ready_o);
        end
        n_cmp++;
        if (bus.busy_o !== 32'h0000_0018) begin
            n_bad++; $display("FAIL fifo_full_busy: got %h, want 00000018", bus.busy_o);
        end
        idle_inputs();
        bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = 32'hA;
        push_exp(1'b1, 5'd3, 32'hA);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL order_first: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        bus.ld_rsp_data_i = 32'hB;
        push_exp(1'b1, 5'd4, 32'hB);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL order_second: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_priority();
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd8; bus.ld_funct3_i = LW;
        tick();
        idle_inputs();
        bus.alu_we_i = 1'b1; bus.alu_waddr_i = 5'd9; bus.alu_wdata_i = 32'h99;
        bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = 32'h55;
        #1;
        n_cmp++;
        if (bus.ld_rsp_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL prio_rsp_ready: got %0b, want 0", bus.ld_rsp_ready_o);
        end
        push_exp(1'b1, 5'd9, 32'h99);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL prio_alu: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        bus.alu_we_i = 1'b0;
        push_exp(1'b1, 5'd8, 32'h55);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL prio_load: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_busy_x0();
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd6; bus.ld_funct3_i = LW;
        tick();
        #1;
        n_cmp++;
        if (bus.ld_issue_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL busy_rd_ready: got %0b, want 0", bus.ld_issue_ready_o);
        end
        bus.ld_rd_i = 5'd0;
        #1;
        n_cmp++;
        if (bus.ld_issue_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL x0_issue_ready: got %0b, want 1", bus.ld_issue_ready_o);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.busy_o !== 32'h0000_0040) begin
            n_bad++; $display("FAIL x0_busy: got %h, want 00000040", bus.busy_o);
        end
        bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = 32'h66;
        push_exp(1'b1, 5'd6, 32'h66);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
            n_bad++;
            $display("FAIL x6_load: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                     bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
        end
        bus.ld_rsp_data_i = 32'h77;
        push_exp(1'b0, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we) begin
            n_bad++; $display("FAIL x0_load_we: we=%0b, want %0b", bus.we_o, e.we);
        end
        n_cmp++;
        if (bus.busy_o !== 32'd0) begin
            n_bad++; $display("FAIL x0_busy_after: got %h, want 0", bus.busy_o);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd12; bus.ld_funct3_i = LW;
        tick();
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            bus.ld_issue_i = (i < 5);
            bus.ld_rd_i = 5'(13 + i);
            bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = d;
            #1;
            if (i < 5) begin
                n_cmp++;
                if (bus.ld_issue_ready_o !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_ready[%0d]: got %0b, want 1", i, bus.ld_issue_ready_o);
                end
            end
            push_exp(1'b1, 5'(12 + i), d);
            tick();
            e = exp_q.pop_front(); n_cmp++;
            if (bus.we_o !== e.we || bus.waddr_o !== e.a || bus.wdata_o !== e.d) begin
                n_bad++;
                $display("FAIL b2b_wb[%0d]: we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
                         i, bus.we_o, bus.waddr_o, bus.wdata_o, e.we, e.a, e.d);
            end
            n_cmp++;
            if (bus.busy_o !== ((i < 5) ? (32'd1 << (13 + i)) : 32'd0)) begin
                n_bad++; $display("FAIL b2b_busy[%0d]: got %h, want %h", i, bus.busy_o,
                                  (i < 5) ? (32'd1 << (13 + i)) : 32'd0);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 5'd10; bus.ld_funct3_i = LW;
        tick();
        bus.ld_rd_i = 5'd11;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.busy_o !== 32'h0000_0C00) begin
            n_bad++; $display("FAIL mid_busy_pre: got %h, want 00000c00", bus.busy_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy_o !== 32'd0) begin
            n_bad++; $display("FAIL mid_busy_post: got %h, want 0", bus.busy_o);
        end
        n_cmp++;
        if (bus.ld_rsp_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL mid_rsp_ready: got %0b, want 0", bus.ld_rsp_ready_o);
        end
        bus.ld_rsp_valid_i = 1'b1; bus.ld_rsp_data_i = 32'hBAD;
        push_exp(1'b0, 5'd0, 32'd0);
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (bus.we_o !== e.we) begin
            n_bad++; $display("FAIL mid_late_rsp: we=%0b, want %0b", bus.we_o, e.we);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu();
        test_load_ext();
        test_in_order();
        test_alu_priority();
        test_busy_x0();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
